// File: rtl/apb_master.sv
// APB3/APB4 initiator: one valid/ready command in, one APB transfer out, one response back.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [3:0]        cmd_strb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [3:0]        pstrb_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  if (DATA_W != 32) begin : gen_bad_data_w
    $error("apb_master: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES == 0) begin : gen_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !pready_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // This wait cycle is the one that brings the count up to the limit.
  assign timeout_hit = (state_q == StAccess) && !pready_i &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      StIdle: begin
        // cmd_ready_q is still low in the first cycle after reset, so it gates the handshake.
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d   = 1'b0;
          pwrite_d      = cmd_write_i;
          paddr_d       = cmd_addr_i;
          pwdata_d      = cmd_wdata_i;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          if (cmd_addr_i[1:0] != 2'b00) begin
            state_d     = StResp;
            pstrb_d     = 4'b0000;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = StSetup;
            psel_d    = 1'b1;
            pstrb_d   = cmd_write_i ? cmd_strb_i : 4'b0000;
            rsp_err_d = 1'b0;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (pready_i || timeout_hit) begin
          state_d     = StResp;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pstrb_d     = 4'b0000;
          rsp_valid_d = 1'b1;
          if (pready_i) begin
            rsp_err_d   = pslverr_i;
            rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
          end else begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= 4'b0000;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: timing, wait states, errors, back-pressure and reset.
// The timeout case runs only when APB_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
module tb_apb_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [11:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  apb_master #(
    .ADDR_W        (12),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .cmd_strb_i   (cmd_strb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command in an IDLE cycle; returns in cycle T+1 after handshake edge T.
  task automatic send_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [3:0] st);
    check_eq("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'h1);
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_strb_i  = st;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
    rsp_ready_i = 1'b1;
    prdata_i    = 32'h0BAD_0BAD;
    pready_i    = 1'b1;
    pslverr_i   = 1'b0;

    #1;
    check_eq("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'h0);
    check_eq("rst_psel", {31'b0, psel_o}, 32'h0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check_eq("rst_paddr", {20'b0, paddr_o}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("post_rst_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);

    // Zero-wait write.
    send_cmd(1'b1, 12'h004, 32'h0000_00A5, 4'b0001);
    check_eq("wr_setup_psel", {31'b0, psel_o}, 32'h1);
    check_eq("wr_setup_penable", {31'b0, penable_o}, 32'h0);
    check_eq("wr_setup_pwrite", {31'b0, pwrite_o}, 32'h1);
    check_eq("wr_setup_paddr", {20'b0, paddr_o}, 32'h004);
    check_eq("wr_setup_pwdata", pwdata_o, 32'h0000_00A5);
    check_eq("wr_setup_pstrb", {28'b0, pstrb_o}, 32'h1);
    check_eq("wr_setup_cmd_ready", {31'b0, cmd_ready_o}, 32'h0);
    step();
    check_eq("wr_access_psel", {31'b0, psel_o}, 32'h1);
    check_eq("wr_access_penable", {31'b0, penable_o}, 32'h1);
    check_eq("wr_access_pstrb", {28'b0, pstrb_o}, 32'h1);
    check_eq("wr_access_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    step();
    check_eq("wr_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
    check_eq("wr_rsp_err", {31'b0, rsp_err_o}, 32'h0);
    check_eq("wr_rsp_rdata", rsp_rdata_o, 32'h0);
    check_eq("wr_rsp_psel", {31'b0, psel_o}, 32'h0);
    check_eq("wr_rsp_pstrb", {28'b0, pstrb_o}, 32'h0);
    check_eq("wr_rsp_paddr_held", {20'b0, paddr_o}, 32'h004);
    step();
    check_eq("wr_next_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check_eq("wr_next_psel", {31'b0, psel_o}, 32'h0);

    // Read with three wait states, ready on the fourth ACCESS cycle.
    pready_i = 1'b0;
    send_cmd(1'b0, 12'h008, 32'hFFFF_FFFF, 4'b1111);
    check_eq("rd_setup_pwrite", {31'b0, pwrite_o}, 32'h0);
    check_eq("rd_setup_pstrb", {28'b0, pstrb_o}, 32'h0);
    check_eq("rd_setup_paddr", {20'b0, paddr_o}, 32'h008);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rd_wait_penable", {31'b0, penable_o}, 32'h1);
      check_eq("rd_wait_pstrb", {28'b0, pstrb_o}, 32'h0);
      check_eq("rd_wait_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    end
    pready_i = 1'b1;
    prdata_i = 32'hDEAD_BEEF;
    step();
    prdata_i = 32'h0BAD_0BAD;
    check_eq("rd_rsp_valid_t6", {31'b0, rsp_valid_o}, 32'h1);
    check_eq("rd_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    check_eq("rd_rsp_err", {31'b0, rsp_err_o}, 32'h0);
    check_eq("rd_rsp_timeout", {31'b0, rsp_timeout_o}, 32'h0);
    check_eq("rd_rsp_penable", {31'b0, penable_o}, 32'h0);
    step();

    // Slave error on a read: data suppressed.
    send_cmd(1'b0, 12'h010, 32'h0, 4'b0000);
    step();
    pslverr_i = 1'b1;
    prdata_i  = 32'h1234_5678;
    step();
    pslverr_i = 1'b0;
    prdata_i  = 32'h0BAD_0BAD;
    check_eq("slverr_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
    check_eq("slverr_rsp_err", {31'b0, rsp_err_o}, 32'h1);
    check_eq("slverr_rsp_rdata", rsp_rdata_o, 32'h0);
    check_eq("slverr_rsp_timeout", {31'b0, rsp_timeout_o}, 32'h0);
    step();

    // Misaligned address: immediate error, no APB activity.
    send_cmd(1'b0, 12'h006, 32'h0, 4'b0000);
    check_eq("mis_rsp_valid_t1", {31'b0, rsp_valid_o}, 32'h1);
    check_eq("mis_rsp_err", {31'b0, rsp_err_o}, 32'h1);
    check_eq("mis_rsp_rdata", rsp_rdata_o, 32'h0);
    check_eq("mis_psel_t1", {31'b0, psel_o}, 32'h0);
    step();
    check_eq("mis_psel_t2", {31'b0, psel_o}, 32'h0);
    check_eq("mis_cmd_ready_t2", {31'b0, cmd_ready_o}, 32'h1);

    // Response back-pressure, with a competing command offered in RESP.
    rsp_ready_i = 1'b0;
    send_cmd(1'b0, 12'h00C, 32'h0, 4'b0000);
    prdata_i = 32'hCAFE_F00D;
    step();
    step();
    prdata_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
      check_eq("bp_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
      check_eq("bp_rsp_err", {31'b0, rsp_err_o}, 32'h0);
      check_eq("bp_cmd_ready", {31'b0, cmd_ready_o}, 32'h0);
      check_eq("bp_psel", {31'b0, psel_o}, 32'h0);
      if (i == 4) begin
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 12'h020;
      end
      step();
    end
    check_eq("bp_after_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
    check_eq("bp_after_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check_eq("bp_after_psel", {31'b0, psel_o}, 32'h0);
    cmd_valid_i = 1'b0;

    // Stuck slave.
    pready_i = 1'b0;
    send_cmd(1'b0, 12'h014, 32'h0, 4'b0000);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("to_access_penable", {31'b0, penable_o}, 32'h1);
    end
    step();
    check_eq("to_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
    check_eq("to_rsp_err", {31'b0, rsp_err_o}, 32'h1);
    check_eq("to_rsp_timeout", {31'b0, rsp_timeout_o}, 32'h1);
    check_eq("to_rsp_rdata", rsp_rdata_o, 32'h0);
    check_eq("to_psel", {31'b0, psel_o}, 32'h0);
    pready_i = 1'b1;
    step();
`else
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("stuck_penable", {31'b0, penable_o}, 32'h1);
      check_eq("stuck_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    end
    pready_i = 1'b1;
    prdata_i = 32'h0000_5A5A;
    step();
    check_eq("stuck_rsp_valid_end", {31'b0, rsp_valid_o}, 32'h1);
    check_eq("stuck_rsp_rdata", rsp_rdata_o, 32'h0000_5A5A);
    check_eq("stuck_rsp_timeout", {31'b0, rsp_timeout_o}, 32'h0);
    step();
`endif

    // Reset asserted in ACCESS.
    pready_i = 1'b0;
    send_cmd(1'b1, 12'h018, 32'h1111_2222, 4'b1111);
    step();
    check_eq("rst_mid_penable_before", {31'b0, penable_o}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_psel", {31'b0, psel_o}, 32'h0);
    check_eq("rst_mid_penable", {31'b0, penable_o}, 32'h0);
    pready_i = 1'b1;
    step();
    check_eq("rst_mid_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("rst_mid_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
    check_eq("rst_mid_no_rsp", {31'b0, rsp_valid_o}, 32'h0);
    step();
    check_eq("rst_mid_no_rsp2", {31'b0, rsp_valid_o}, 32'h0);
    check_eq("rst_mid_psel2", {31'b0, psel_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that turns single-transfer commands from an internal requester (test sequencer, bridge, or CPU-side shim) into APB3/APB4 transfers toward the UART register file, and returns read data and error status. Commands and responses use valid/ready handshakes. One transfer is in flight at a time. The block drives the SETUP/ACCESS phases and honours PREADY wait states.

## Interface
- ADDR_W, 12: APB address width.
- DATA_W, 32: APB data width; must be 32.
- TIMEOUT_CYCLES, 256: ACCESS-phase wait limit; used only with APB_MASTER_TIMEOUT_EN.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted this cycle when both valid and ready are high.
- cmd_write_i  input  1  1 = write, 0 = read.
- cmd_addr_i  input  ADDR_W  byte address.
- cmd_wdata_i  input  32  write data.
- cmd_strb_i  input  4  write byte strobes.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  32  read data; 0 for writes and errors.
- rsp_err_o  output  1  PSLVERR, misalignment, or timeout.
- rsp_timeout_o  output  1  the error was a timeout.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- pwrite_o  output  1  APB direction.
- paddr_o  output  ADDR_W  APB address.
- pwdata_o  output  32  APB write data.
- pstrb_o  output  4  APB strobes.
- prdata_i  input  32  APB read data.
- pready_i  input  1  APB ready.
- pslverr_i  input  1  APB slave error.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. Reset enters IDLE.
- Reset values: all outputs 0, including cmd_ready_o. cmd_ready_o rises in the first IDLE cycle after reset deasserts.
- IDLE:
  - cmd_ready_o = 1 in IDLE only.
  - On handshake, the block registers write, addr, wdata and strb.
  - If cmd_addr_i[1:0] != 0, the block skips APB and goes to RESP with err=1 and rdata=0.
  - Otherwise it goes to SETUP.
- SETUP:
  - psel_o=1 and penable_o=0.
  - paddr_o, pwrite_o and pwdata_o come from the registered command.
  - pstrb_o = strb on writes and 4'b0000 on reads.
  - Unconditionally goes to ACCESS.
- ACCESS:
  - psel_o=1 and penable_o=1; all address, data and control signals are held stable.
  - While pready_i=0, the block stays in ACCESS.
  - When pready_i=1:
    - Capture pslverr_i into rsp_err_o.
    - Capture prdata_i into rsp_rdata_o on error-free reads; otherwise rsp_rdata_o = 0.
    - Go to RESP.
- RESP:
  - psel_o=0 and penable_o=0; paddr_o, pwdata_o and pwrite_o keep their last values; pstrb_o is driven to 0.
  - rsp_valid_o=1, with rsp_* held stable until rsp_ready_i=1.
  - After the response handshake, goes to IDLE.
- pslverr_i and prdata_i are ignored outside ACCESS cycles with pready_i=1.
- Reset asserted mid-transfer: psel_o and penable_o drop immediately (asynchronously), any pending response is discarded, and the FSM returns to IDLE.

## Timing
- Command handshake at edge T gives:
  - SETUP during cycle T+1;
  - ACCESS from T+2;
  - with pready_i=1 in the first ACCESS cycle, rsp_valid_o=1 in cycle T+3.
- Each wait cycle (pready_i=0 in ACCESS) adds one cycle to the latency.
- Misaligned command at T: rsp_valid_o=1 at T+1, and no psel_o pulse is produced.
- Back-to-back throughput:
  - If rsp_ready_i is held at 1, the response handshake completes in its first RESP cycle. The next cmd_ready_o appears in the cycle after, which gives 4 cycles per zero-wait transfer.
  - psel_o is always low for at least one cycle between transfers.
- Simultaneous rsp_ready_i and cmd_valid_i in RESP: the command is not accepted, because cmd_ready_o=0 in RESP.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES with pready_i still 0, the block leaves ACCESS for RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
  - If pready_i=1 in the same cycle the count reaches the limit, it is a normal completion and rsp_timeout_o=0.
- Not defined:
  - No counter is built, and the block waits indefinitely for pready_i.
  - rsp_timeout_o is tied to 0.

## Test plan
- Write 0x000000A5 to 0x004 with strb 4'b0001, with pready_i always 1:
  - SETUP at T+1 shows psel_o=1, penable_o=0, pwrite_o=1, paddr_o=0x004, pstrb_o=4'b0001;
  - ACCESS at T+2;
  - rsp_valid_o at T+3 with rsp_err_o=0 and rsp_rdata_o=0.
- Read 0x008, with pready_i low for 3 ACCESS cycles and prdata_i=0xDEADBEEF on the ready cycle:
  - penable_o stays high for 4 cycles with pstrb_o=0;
  - rsp_rdata_o=0xDEADBEEF and rsp_valid_o at T+6.
- Read 0x010 with pslverr_i=1 and prdata_i=0x12345678 at ready -> rsp_err_o=1, rsp_rdata_o=0.
- Command to 0x006 -> no psel_o assertion; rsp_valid_o at T+1 with rsp_err_o=1.
- Hold rsp_ready_i=0 for 5 cycles in RESP:
  - rsp_* stay stable, cmd_ready_o=0, psel_o=0;
  - after the handshake, cmd_ready_o=1 in the next cycle.
- Timeout, with the macro defined and TIMEOUT_CYCLES=4: pready_i stuck at 0 -> 4 ACCESS cycles, then RESP with rsp_err_o=1 and rsp_timeout_o=1.
- Reset in ACCESS -> psel_o and penable_o go to 0 immediately, with no response generated.
